sumsq_prep: RTL and testbench
=============================

Name: sumsq_prep

Overview:
- Upstream feeder for the iterative integer square-root stage.
- Accepts a signed (x, y) vector pair over a valid/ready handshake and computes the 8-bit operand x^2 + y^2 with a sequential shift-add multiplier.
- Presents the result on a valid/ready output held stable until consumed, so the sqrt stage yields vector magnitude floor(sqrt(x^2 + y^2)).

Parameters:
- IN_W, 4, width of each signed two's-complement input component.
- OUT_W, 2*IN_W (8), result width. 2*(2^(IN_W-1))^2 = 2^(2*IN_W-1) always fits, so no saturation logic is needed.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  input pair valid
- in_ready  output  1  block can accept a pair
- in_x  input  IN_W  signed x component
- in_y  input  IN_W  signed y component
- out_valid  output  1  out_data holds a completed result
- out_ready  input  1  downstream (sqrt stage) accepts result
- out_data  output  OUT_W  unsigned x^2 + y^2
- busy  output  1  high in MUL or OUT state

Behaviour:
- One clock. Reset is asynchronous and active-high.
- Reset values:
  - state=IDLE, out_valid=0, out_data=0, busy=0.
  - in_ready=1, since it is decoded from state.
  - Internal magnitude, accumulator and counter registers are 0.
- FSM states: IDLE, MUL, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid=1 at a rising edge, capture ax=|in_x| and ay=|in_y| as IN_W-bit unsigned values (-2^(IN_W-1) maps to 2^(IN_W-1), which fits).
  - On the same edge, clear the accumulator and counter, and go to MUL.
- MUL:
  - in_ready=0. Runs exactly IN_W cycles, bit index i = counter from 0 to IN_W-1.
  - Each cycle: acc += (ax[i] ? ax<<i : 0) + (ay[i] ? ay<<i : 0), computed in OUT_W bits.
  - counter increments each cycle.
  - When counter==IN_W-1, load out_data with the final acc and go to OUT.
- OUT:
  - out_valid=1. out_data is stable while out_ready=0, with no limit on stall length.
  - On out_ready=1 at a rising edge, the transfer completes, out_valid drops, and the state returns to IDLE.
- Latency:
  - out_valid rises IN_W cycles after the acceptance edge (4 cycles at default).
  - Minimum initiation interval is IN_W+2 cycles: one IDLE cycle, IN_W MUL cycles, at least one OUT cycle.
- in_valid is ignored outside IDLE. in_x and in_y may change freely after acceptance.
- out_ready is ignored outside OUT.
- Back-to-back operation: with in_valid held high, the next pair is accepted on the first edge the block is in IDLE after the output transfer.
- Reset asserted mid-MUL or mid-OUT:
  - out_valid drops and state goes to IDLE immediately (asynchronous).
  - The partial result is discarded and never presented.
- No arithmetic overflow is possible at any IN_W. The accumulator never wraps.

Test Plan:
- x=3, y=4, out_ready=1 → out_valid high exactly 4 cycles after acceptance, out_data=25 (0x19), in_ready=0 throughout MUL/OUT.
- x=-8, y=-8 (most negative) → out_data=128 (0x80). x=0, y=0 → out_data=0, with the same latency.
- x=-5, y=2 with out_ready held 0 for 6 cycles → out_data=29 and out_valid=1 stable for all 6 cycles. in_ready=0, and a new in_valid pair is not accepted. Transfer completes on the first edge with out_ready=1.
- in_valid held high with pairs (7,-1) then (-3,2) → results 50 then 13 in order. The second pair is accepted one cycle after the first output handshake, and no pair is dropped or duplicated.
- Assert rst for 1 cycle during the 2nd MUL cycle of (5,5) → out_valid stays 0, no result 50 appears, in_ready=1 immediately. A following pair (1,1) yields 2.
- Sweep all 256 (x,y) combinations at IN_W=4 against a reference model → every out_data equals x*x+y*y.

Source files
------------

// File: rtl/sumsq_prep.sv
// Operand feeder for the integer sqrt stage: takes a signed (x, y) pair and
// produces x^2 + y^2 with a bit-serial shift-add multiplier, one bit per cycle.
module sumsq_prep #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 2 * IN_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_x,
  input  logic signed [IN_W-1:0]  in_y,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        out_data,
  output logic                    busy
);

  localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(IN_W - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  logic [1:0]       r_state;
  logic [IN_W-1:0]  r_ax;
  logic [IN_W-1:0]  r_ay;
  logic [OUT_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [OUT_W-1:0] r_out;

  logic [IN_W-1:0]  w_ax_abs;
  logic [IN_W-1:0]  w_ay_abs;
  logic [OUT_W-1:0] w_term_x;
  logic [OUT_W-1:0] w_term_y;
  logic [OUT_W-1:0] w_acc_next;

  // Negating the most negative value wraps back to itself, which read as
  // unsigned is exactly 2^(IN_W-1), so no extra bit is needed.
  always_comb begin
    w_ax_abs = in_x[IN_W-1] ? $unsigned(-in_x) : $unsigned(in_x);
    w_ay_abs = in_y[IN_W-1] ? $unsigned(-in_y) : $unsigned(in_y);
  end

  always_comb begin
    w_term_x   = r_ax[r_cnt] ? (OUT_W'(r_ax) << r_cnt) : '0;
    w_term_y   = r_ay[r_cnt] ? (OUT_W'(r_ay) << r_cnt) : '0;
    w_acc_next = r_acc + w_term_x + w_term_y;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ax    <= '0;
      r_ay    <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_out   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_ax    <= w_ax_abs;
            r_ay    <= w_ay_abs;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= S_MUL;
          end
        end
        S_MUL: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_BIT) begin
            r_out   <= w_acc_next;
            r_state <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_OUT);
  assign busy      = (r_state == S_MUL) || (r_state == S_OUT);
  assign out_data  = r_out;

endmodule

// File: tb/tb_sumsq_prep.sv
// Self-checking bench for sumsq_prep: directed handshake/latency scenarios and
// a full (x, y) sweep with random output stalls against an arithmetic model.
module tb_sumsq_prep;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic signed [3:0] in_x;
  logic signed [3:0] in_y;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_data;
  logic              busy;

  int checks;
  int errors;

  sumsq_prep #(.IN_W(4), .OUT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ref_sumsq(input int x, input int y);
    return x * x + y * y;
  endfunction

  // Presents one pair in IDLE, measures edges from acceptance to out_valid,
  // waits `stall` cycles with out_ready low, then completes the transfer.
  task automatic do_pair(input int x, input int y, input int stall,
                         output int lat, output logic [7:0] data,
                         output bit rdy_low);
    logic [31:0] vx;
    logic [31:0] vy;
    vx = x;
    vy = y;
    in_valid = 1'b1;
    in_x = vx[3:0];
    in_y = vy[3:0];
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_x = 4'($urandom);
    in_y = 4'($urandom);
    lat = 0;
    rdy_low = 1'b1;
    data = 8'h00;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (in_ready) rdy_low = 1'b0;
    end
    if (out_valid) begin
      data = out_data;
      for (int s = 0; s < stall; s++) begin
        @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_x = '0;
    in_y = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int lat;
    logic [7:0] d;
    bit rl;
    do_pair(3, 4, 0, lat, d, rl);
    checks++; if (lat !== 4) begin errors++; $display("FAIL basic_latency got=%0d exp=4", lat); end
    checks++; if (d !== 8'(ref_sumsq(3, 4))) begin errors++; $display("FAIL basic_data got=%0d exp=%0d", d, ref_sumsq(3, 4)); end
    checks++; if (rl !== 1'b1) begin errors++; $display("FAIL basic_in_ready_low got=%b exp=1", rl); end
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL basic_post_transfer got=%b%b exp=10", in_ready, out_valid); end
  endtask

  task automatic test_extremes;
    int lat;
    logic [7:0] d;
    bit rl;
    do_pair(-8, -8, 0, lat, d, rl);
    checks++; if (d !== 8'(ref_sumsq(-8, -8))) begin errors++; $display("FAIL extreme_neg_data got=%0d exp=%0d", d, ref_sumsq(-8, -8)); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL extreme_neg_latency got=%0d exp=4", lat); end
    do_pair(0, 0, 0, lat, d, rl);
    checks++; if (d !== 8'(ref_sumsq(0, 0))) begin errors++; $display("FAIL zero_data got=%0d exp=0", d); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL zero_latency got=%0d exp=4", lat); end
  endtask

  task automatic test_stall;
    int lat;
    int bad;
    int exp;
    exp = ref_sumsq(-5, 2);
    in_valid = 1'b1;
    in_x = -4'sd5;
    in_y = 4'sd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (lat !== 4) begin errors++; $display("FAIL stall_latency got=%0d exp=4", lat); end
    // offer another pair during the stall; it must not be taken
    in_valid = 1'b1;
    in_x = 4'sd1;
    in_y = 4'sd1;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid !== 1'b1 || out_data !== 8'(exp) || in_ready !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL stall_hold bad_cycles=%0d exp=0 data=%0d exp_data=%0d", bad, out_data, exp); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_still_valid got=%b exp=1", out_valid); end
    out_ready = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL stall_transfer got=%b%b exp=01", out_valid, in_ready); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_no_accept busy got=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back;
    int lat;
    in_valid = 1'b1;
    in_x = 4'sd7;
    in_y = -4'sd1;
    @(posedge clk); #1;
    in_x = -4'sd3;
    in_y = 4'sd2;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (lat !== 4) begin errors++; $display("FAIL b2b_first_latency got=%0d exp=4", lat); end
    checks++; if (out_data !== 8'(ref_sumsq(7, -1))) begin errors++; $display("FAIL b2b_first_data got=%0d exp=%0d", out_data, ref_sumsq(7, -1)); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap got=%b%b exp=10", in_ready, busy); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL b2b_second_accept got=%b%b exp=10", busy, in_ready); end
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (lat !== 4) begin errors++; $display("FAIL b2b_second_latency got=%0d exp=4", lat); end
    checks++; if (out_data !== 8'(ref_sumsq(-3, 2))) begin errors++; $display("FAIL b2b_second_data got=%0d exp=%0d", out_data, ref_sumsq(-3, 2)); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL b2b_no_duplicate got=%b%b exp=00", busy, out_valid); end
  endtask

  task automatic test_reset_mid;
    int seen;
    int lat;
    logic [7:0] d;
    bit rl;
    in_valid = 1'b1;
    in_x = 4'sd5;
    in_y = 4'sd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL midreset_async got=%b%b%b exp=100", in_ready, busy, out_valid); end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid === 1'b1) seen++;
      @(posedge clk); #1;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL midreset_no_result got=%0d exp=0", seen); end
    do_pair(1, 1, 0, lat, d, rl);
    checks++; if (d !== 8'(ref_sumsq(1, 1)) || lat !== 4) begin errors++; $display("FAIL midreset_next got=%0d lat=%0d exp=2 lat=4", d, lat); end
  endtask

  task automatic test_sweep;
    int lat;
    logic [7:0] d;
    bit rl;
    for (int x = -8; x < 8; x++) begin
      for (int y = -8; y < 8; y++) begin
        do_pair(x, y, int'($urandom_range(0, 2)), lat, d, rl);
        checks++;
        if (d !== 8'(ref_sumsq(x, y)) || lat !== 4) begin
          errors++;
          $display("FAIL sweep x=%0d y=%0d got=%0d lat=%0d exp=%0d lat=4", x, y, d, lat, ref_sumsq(x, y));
        end
        if ($urandom_range(0, 1) == 1) begin
          @(posedge clk); #1;
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset;
    test_basic;
    test_extremes;
    test_stall;
    test_back_to_back;
    test_reset_mid;
    test_sweep;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
